// File: rtl/pc_return_stack_if.sv
// Bus bundle between the fetch-path controller and the return-address stack.
// The controller drives in/push/pop and observes top-of-stack and status.
interface pc_return_stack_if #(
   parameter int WIDTH = 16,
   parameter int PTR_W = 3
);
   logic [WIDTH-1:0] in;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] out;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output in, push, pop,
      input  out, count, empty, full, overflow, underflow
   );

   modport slave (
      input  in, push, pop,
      output out, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/pc_return_stack.sv
// Return-address stack (LIFO) beside the PC; top-of-stack feeds the PC load path.
// Optional feature: define RAS_WRAP_EN to let a push to a full stack overwrite the oldest entry.
module pc_return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic clock,
   input  logic reset,
   pc_return_stack_if.slave bus
);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] top;
   logic [PTR_W-1:0] top_prev;
   logic             ovf;
   logic             unf;
   logic             is_empty;
   logic             is_full;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic             advance;
   logic             retreat;

   // top points at the next free slot; the live top entry sits one below it
   assign top_prev = top - PTR_ONE;
   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_CNT);

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = top;
      advance = 1'b0;
      retreat = 1'b0;
      if (bus.push && (!bus.pop || is_empty)) begin
         if (!is_full) begin
            wr_en   = 1'b1;
            advance = 1'b1;
         end
`ifdef RAS_WRAP_EN
         else begin
            // when full, top aliases the oldest slot, so this overwrites it
            wr_en   = 1'b1;
            advance = 1'b1;
         end
`endif
      end else if (bus.push && bus.pop) begin
         wr_en   = 1'b1;
         wr_addr = top_prev;
      end else if (bus.pop && !is_empty) begin
         retreat = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         top   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         if (advance) begin
            top <= top + PTR_ONE;
            if (!is_full)
               count <= count + CNT_ONE;
         end else if (retreat) begin
            top   <= top_prev;
            count <= count - CNT_ONE;
         end
         if (bus.push && !bus.pop && is_full)
            ovf <= 1'b1;
         if (bus.pop && !bus.push && is_empty)
            unf <= 1'b1;
      end
   end

   // storage is deliberately left uncleared by reset
   always_ff @(posedge clock) begin
      if (wr_en && !reset)
         mem[wr_addr] <= bus.in;
   end

   assign bus.out       = is_empty ? '0 : mem[top_prev];
   assign bus.count     = count;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = ovf;
   assign bus.underflow = unf;
endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack; expectations follow RAS_WRAP_EN when defined.
module tb_pc_return_stack;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   pc_return_stack_if #(.WIDTH(16), .PTR_W(3)) bus ();

   pc_return_stack #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #2 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // one rising edge with the given request, then sample on the falling edge
   task automatic step(input logic p, input logic q, input logic [15:0] d);
      bus.push = p;
      bus.pop  = q;
      bus.in   = d;
      @(posedge clock);
      @(negedge clock);
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.in   = '0;

      // 1: reset
      step(0, 0, 0);
      step(0, 0, 0);
      reset = 1'b0;
      chk("rst_out",   32'(bus.out), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full",  32'(bus.full), 0);
      chk("rst_ovf",   32'(bus.overflow), 0);
      chk("rst_unf",   32'(bus.underflow), 0);

      // 2: push three, pop three
      step(1, 0, 7);   chk("p7_out", 32'(bus.out), 7);  chk("p7_cnt", 32'(bus.count), 1);
      chk("p7_empty", 32'(bus.empty), 0);
      step(1, 0, 12);  chk("p12_out", 32'(bus.out), 12);
      step(1, 0, 300); chk("p300_out", 32'(bus.out), 300); chk("p300_cnt", 32'(bus.count), 3);
      step(0, 1, 0);   chk("pop1_out", 32'(bus.out), 12);
      step(0, 1, 0);   chk("pop2_out", 32'(bus.out), 7);
      step(0, 1, 0);   chk("pop3_out", 32'(bus.out), 0);  chk("pop3_empty", 32'(bus.empty), 1);
      chk("pop3_unf", 32'(bus.underflow), 0);

      // 3: underflow is sticky
      step(0, 1, 0);   chk("uf_cnt", 32'(bus.count), 0); chk("uf_flag", 32'(bus.underflow), 1);
      step(1, 0, 5);   chk("uf_p5_out", 32'(bus.out), 5); chk("uf_p5_flag", 32'(bus.underflow), 1);
      step(0, 1, 0);   chk("uf_drain", 32'(bus.count), 0);

      // 4: fill, then push into a full stack
      for (int i = 1; i <= 8; i++) step(1, 0, 16'(i));
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_out",  32'(bus.out), 8);
      chk("fill_cnt",  32'(bus.count), 8);
      chk("fill_ovf",  32'(bus.overflow), 0);
      step(1, 0, 9);
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_cnt",  32'(bus.count), 8);
`ifdef RAS_WRAP_EN
      chk("ovf_out", 32'(bus.out), 9);
      for (int i = 9; i >= 2; i--) begin
         chk("drain_top", 32'(bus.out), 32'(i));
         step(0, 1, 0);
      end
`else
      chk("ovf_out", 32'(bus.out), 8);
      for (int i = 8; i >= 1; i--) begin
         chk("drain_top", 32'(bus.out), 32'(i));
         step(0, 1, 0);
      end
`endif
      chk("drain_empty", 32'(bus.empty), 1);
      chk("drain_out",   32'(bus.out), 0);

      // 5: simultaneous push and pop replaces the top
      step(1, 0, 7);
      step(1, 0, 12);
      step(1, 1, 40);  chk("rep_cnt", 32'(bus.count), 2); chk("rep_out", 32'(bus.out), 40);
      step(0, 1, 0);   chk("rep_pop_out", 32'(bus.out), 7);

      // 6: reset mid-sequence wins over push
      step(1, 0, 20);
      step(1, 0, 21);
      chk("pre_rst_cnt", 32'(bus.count), 3);
      reset = 1'b1;
      step(1, 0, 99);
      reset = 1'b0;
      chk("mid_rst_cnt", 32'(bus.count), 0);
      chk("mid_rst_out", 32'(bus.out), 0);
      chk("mid_rst_ovf", 32'(bus.overflow), 0);
      chk("mid_rst_unf", 32'(bus.underflow), 0);
      step(1, 0, 4);   chk("post_rst_out", 32'(bus.out), 4); chk("post_rst_cnt", 32'(bus.count), 1);

      // push and pop together on an empty stack acts as a plain push
      step(0, 1, 0);
      step(1, 1, 3);
      chk("pp_empty_cnt", 32'(bus.count), 1);
      chk("pp_empty_out", 32'(bus.out), 3);
      chk("pp_empty_unf", 32'(bus.underflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
